// File: rtl/uart_rx_line_buffer.sv
// Byte FIFO behind the UART receiver: counts stored line terminators and drops
// the tail of any line that overflows, so the consumer never sees merged lines.
module uart_rx_line_buffer #(
  parameter int         DEPTH  = 16,
  parameter int         ADDR_W = 4,
  parameter logic [7:0] TERM   = 8'h0A
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              rd_en,
  input  logic              clr_overflow,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   line_count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic {NORMAL, DISCARD} wr_state_e;

  wr_state_e         state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d, lines_q, lines_d;
  logic              empty_q, full_q, ovf_q, ovf_d, rd_valid_q;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              is_term, head_term, wr_acc, rd_acc, drop;

  always_comb begin
    is_term   = (rx_data == TERM);
    head_term = (mem_q[rd_ptr_q] == TERM);
    // In DISCARD only a terminator may be stored, closing the truncated line.
    wr_acc    = rx_done && !full_q && ((state_q == NORMAL) || is_term);
    drop      = rx_done && !wr_acc;
    rd_acc    = rd_en && !empty_q;

    state_d = state_q;
    if (rx_done) begin
      case (state_q)
        NORMAL:  if (full_q) state_d = DISCARD;
        DISCARD: if (is_term && !full_q) state_d = NORMAL;
        default: state_d = NORMAL;
      endcase
    end

    wr_ptr_d  = wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d  = rd_ptr_q + ADDR_W'(rd_acc);
    count_d   = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    lines_d   = lines_q + (ADDR_W+1)'(wr_acc && is_term)
                        - (ADDR_W+1)'(rd_acc && head_term);
    rd_data_d = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;

    // Tail bytes of a discarded line do not re-raise the flag; set beats clear.
    ovf_d = ovf_q;
    if (drop && ((state_q == NORMAL) || is_term)) ovf_d = 1'b1;
    else if (clr_overflow)                         ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= NORMAL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lines_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lines_q    <= lines_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == DEPTH_C);
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_acc;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign line_count = lines_q;
  assign overflow   = ovf_q;

endmodule
